// File: rtl/video_timing_ctrl.sv
// Raster timing controller for the colour-bar generator: h/v counters, sync, DE,
// and a pixel request that leads video_de by one cycle. Starts/stops on frame boundaries.
module video_timing_ctrl #(
    parameter int       H_SYNC   = 40,
    parameter int       H_BACK   = 220,
    parameter int       H_DISP   = 1280,
    parameter int       H_FRONT  = 110,
    parameter int       V_SYNC   = 5,
    parameter int       V_BACK   = 20,
    parameter int       V_DISP   = 720,
    parameter int       V_FRONT  = 5,
    parameter logic     SYNC_POL = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        video_en,
    output logic        busy,
    output logic        frame_start,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic        data_req,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos
);

    localparam logic [11:0] H_TOTAL  = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT);
    localparam logic [11:0] V_TOTAL  = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT);
    localparam logic [11:0] HA       = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] VA       = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] HS_END   = 12'(H_SYNC);
    localparam logic [11:0] VS_END   = 12'(V_SYNC);
    localparam logic [11:0] HA_END   = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] VA_END   = 12'(V_SYNC + V_BACK + V_DISP);
    localparam logic [11:0] REQ_BEG  = HA - 12'd1;
    localparam logic [11:0] REQ_END  = HA_END - 12'd1;
    localparam logic [11:0] H_LAST   = H_TOTAL - 12'd1;
    localparam logic [11:0] V_LAST   = V_TOTAL - 12'd1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [11:0] v_ext;

    assign v_ext = {1'b0, v_cnt_q};

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Leaving RUN is only possible on the last pixel of the last line.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (video_en) state_d = RUN;
            end
            RUN: begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    if (v_ext == V_LAST) begin
                        v_cnt_d = '0;
                        if (!video_en) state_d = IDLE;
                    end else begin
                        v_cnt_d = v_cnt_q + 11'd1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic v_act;
    logic [11:0] xdiff;
    logic [11:0] ydiff;

    assign v_act = (v_ext >= VA) && (v_ext < VA_END);
    assign xdiff = h_cnt_q - REQ_BEG;
    assign ydiff = v_ext - VA;

    always_comb begin
        busy        = 1'b0;
        frame_start = 1'b0;
        video_hs    = ~SYNC_POL;
        video_vs    = ~SYNC_POL;
        video_de    = 1'b0;
        data_req    = 1'b0;
        pixel_xpos  = '0;
        pixel_ypos  = '0;
        if (state_q == RUN) begin
            busy        = 1'b1;
            frame_start = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);
            video_hs    = (h_cnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
            video_vs    = (v_ext < VS_END) ? SYNC_POL : ~SYNC_POL;
            video_de    = (h_cnt_q >= HA) && (h_cnt_q < HA_END) && v_act;
            // Request runs one column early to cover the generator's register stage.
            data_req    = (h_cnt_q >= REQ_BEG) && (h_cnt_q < REQ_END) && v_act;
            if (data_req) begin
                pixel_xpos = xdiff[10:0];
                pixel_ypos = ydiff[10:0];
            end
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl with a shrunken raster; expected outputs come from
// a frame-position model (run flag + cycle index within the frame).
module tb_video_timing_ctrl;

    localparam int   HS = 3, HB = 4, HD = 8, HF = 2;
    localparam int   VS = 2, VB = 2, VD = 4, VF = 1;
    localparam int   HT = HS + HB + HD + HF;
    localparam int   VT = VS + VB + VD + VF;
    localparam int   HA = HS + HB;
    localparam int   VA = VS + VB;
    localparam int   FRAME = HT * VT;
    localparam logic POL = 1'b1;

    logic        pixel_clk, rst, video_en;
    logic        busy, frame_start, video_hs, video_vs, video_de, data_req;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic [27:0] obs, expv;

    video_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .SYNC_POL(POL)
    ) dut (
        .pixel_clk(pixel_clk), .rst(rst), .video_en(video_en),
        .busy(busy), .frame_start(frame_start), .video_hs(video_hs),
        .video_vs(video_vs), .video_de(video_de), .data_req(data_req),
        .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos)
    );

    assign obs = {busy, frame_start, video_hs, video_vs, video_de, data_req, pixel_xpos, pixel_ypos};

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    bit m_run = 0;
    int m_t = 0;

    function automatic logic [27:0] exp_out(input bit run, input int t);
        int h, v;
        logic de, req;
        logic [10:0] x, y;
        if (!run) return {2'b00, ~POL, ~POL, 2'b00, 22'd0};
        h   = t % HT;
        v   = t / HT;
        de  = (h >= HA) && (h < HA + HD) && (v >= VA) && (v < VA + VD);
        req = (h >= HA - 1) && (h < HA + HD - 1) && (v >= VA) && (v < VA + VD);
        x   = req ? 11'(h - HA + 1) : 11'd0;
        y   = req ? 11'(v - VA) : 11'd0;
        return {1'b1, (t == 0), (h < HS) ? POL : ~POL, (v < VS) ? POL : ~POL, de, req, x, y};
    endfunction

    // One clock: drive enable, advance the model on the edge, settle 1 ns past it.
    task automatic cyc(input bit en);
        video_en = en;
        @(posedge pixel_clk);
        cyc_cnt++;
        if (rst) begin
            m_run = 0; m_t = 0;
        end else if (!m_run) begin
            if (en) begin m_run = 1; m_t = 0; end
        end else if (m_t == FRAME - 1) begin
            m_t = 0;
            if (!en) m_run = 0;
        end else begin
            m_t++;
        end
        #1;
        expv = exp_out(m_run, m_t);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL reset obs=%h exp=%h", obs, expv); end
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL idle obs=%h exp=%h", obs, expv); end
        end
    endtask

    task automatic test_frame_start();
        int nhs = 0, nvs = 0, nfs = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1'b1);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL frame_start t=%0d obs=%h exp=%h", m_t, obs, expv); end
            nhs += int'(video_hs); nvs += int'(video_vs); nfs += int'(frame_start);
        end
        checks++;
        if (nfs !== 2) begin errors++; $display("FAIL fs_count got=%0d exp=2", nfs); end
        checks++;
        if (nhs !== 2 * HS * VT) begin errors++; $display("FAIL hs_count got=%0d exp=%0d", nhs, 2 * HS * VT); end
        checks++;
        if (nvs !== 2 * VS * HT) begin errors++; $display("FAIL vs_count got=%0d exp=%0d", nvs, 2 * VS * HT); end
    endtask

    task automatic test_alignment();
        int nde = 0, nreq = 0, maxx = 0, lasty = 0;
        for (int i = 0; i < FRAME; i++) begin
            cyc(1'b1);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL align t=%0d obs=%h exp=%h", m_t, obs, expv); end
            nde += int'(video_de);
            if (data_req) begin
                nreq++;
                if (int'(pixel_xpos) > maxx) maxx = int'(pixel_xpos);
                lasty = int'(pixel_ypos);
            end
        end
        checks++;
        if (nde !== HD * VD) begin errors++; $display("FAIL de_count got=%0d exp=%0d", nde, HD * VD); end
        checks++;
        if (nreq !== HD * VD) begin errors++; $display("FAIL req_count got=%0d exp=%0d", nreq, HD * VD); end
        checks++;
        if (maxx !== HD - 1) begin errors++; $display("FAIL last_xpos got=%0d exp=%0d", maxx, HD - 1); end
        checks++;
        if (lasty !== VD - 1) begin errors++; $display("FAIL last_ypos got=%0d exp=%0d", lasty, VD - 1); end
    endtask

    task automatic test_stop_mid();
        int guard = 0;
        while (m_run && (m_t / HT) != 5 && guard < 2 * FRAME) begin
            cyc(1'b1); guard++;
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL stop_pre t=%0d obs=%h exp=%h", m_t, obs, expv); end
        end
        guard = 0;
        while (m_run && guard < 2 * FRAME) begin
            cyc(1'b0); guard++;
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL stop_drain t=%0d obs=%h exp=%h", m_t, obs, expv); end
        end
        checks++;
        if (m_run) begin errors++; $display("FAIL stop_timeout run=%0d exp=0", m_run); end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL stop_idle obs=%h exp=%h", obs, expv); end
        end
    endtask

    task automatic test_reenable();
        int last_fs = -1, nfs = 0;
        bit en;
        for (int i = 0; i < 3 * FRAME; i++) begin
            en = !(i < FRAME && (m_t / HT) >= 2 && (m_t / HT) < 6);
            cyc(en);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL reenable t=%0d obs=%h exp=%h", m_t, obs, expv); end
            if (frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc_cnt - last_fs !== FRAME) begin
                        errors++; $display("FAIL fs_period got=%0d exp=%0d", cyc_cnt - last_fs, FRAME);
                    end
                end
                last_fs = cyc_cnt; nfs++;
            end
        end
        checks++;
        if (nfs !== 3) begin errors++; $display("FAIL reenable_fs got=%0d exp=3", nfs); end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        while (m_t != 4 * HT + 8 && guard < 2 * FRAME) begin
            cyc(1'b1); guard++;
        end
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL areset_pre obs=%h exp=%h", obs, expv); end
        #3 rst = 1'b1;
        #1;
        m_run = 0; m_t = 0;
        expv = exp_out(1'b0, 0);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL areset_now obs=%h exp=%h", obs, expv); end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL areset_hold obs=%h exp=%h", obs, expv); end
        end
        rst = 1'b0;
        for (int i = 0; i < FRAME + 5; i++) begin
            cyc(1'b1);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL areset_restart t=%0d obs=%h exp=%h", m_t, obs, expv); end
        end
    endtask

    task automatic test_random();
        bit en = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 19) == 0) en = ($urandom_range(0, 99) < 55);
            cyc(en);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL random t=%0d obs=%h exp=%h", m_t, obs, expv); end
        end
    endtask

    initial begin
        rst = 1'b1;
        video_en = 1'b0;
        test_reset();
        test_frame_start();
        test_alignment();
        test_stop_mid();
        test_reenable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
- Raster timing controller that sequences the colour-bar pixel generator. It produces the horizontal and vertical counters, HDMI/DVI sync and data-enable, and a pixel request with coordinates.
- The request and coordinates lead `video_de` by exactly one `pixel_clk`, which absorbs the generator's one-cycle registered pixel latency.
- Frame-aligned start/stop: it only ever starts or stops at a frame boundary, so the encoder never sees a partial frame.

Parameters:
- H_SYNC, 40, hsync width in pixels
- H_BACK, 220, horizontal back porch
- H_DISP, 1280, active pixels per line
- H_FRONT, 110, horizontal front porch
- V_SYNC, 5, vsync width in lines
- V_BACK, 20, vertical back porch
- V_DISP, 720, active lines
- V_FRONT, 5, vertical front porch
- SYNC_POL, 1'b1, active level of `video_hs`/`video_vs` (1 = active-high)

Ports:
- pixel_clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- video_en  in  1  request to run timing; sampled every cycle
- busy  out  1  high while in RUN
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0 in RUN
- video_hs  out  1  horizontal sync
- video_vs  out  1  vertical sync
- video_de  out  1  active-video data enable
- data_req  out  1  pixel request, one cycle ahead of `video_de`
- pixel_xpos  out  11  requested pixel column, 0..H_DISP-1
- pixel_ypos  out  11  requested pixel row, 0..V_DISP-1

Behaviour:
- **Derived constants**
  - H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT (1650).
  - V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT (750).
  - HA = H_SYNC+H_BACK (260); VA = V_SYNC+V_BACK (25).
- **State** (registered): state ∈ {IDLE, RUN}; h_cnt[11:0]; v_cnt[10:0].
- **Reset** (async, rst=1):
  - state=IDLE, h_cnt=0, v_cnt=0.
  - All outputs at idle values: video_hs=video_vs=~SYNC_POL; video_de, data_req, frame_start, busy = 0; pixel_xpos = pixel_ypos = 0.
  - Reset asserted mid-frame aborts the frame immediately; no completion.
- **IDLE**
  - Counters held at 0; outputs at idle values.
  - video_en=1 → RUN on the next edge. The first RUN cycle has h_cnt=0, v_cnt=0, so frame_start fires in that first RUN cycle.
- **RUN, counters**
  - h_cnt increments every cycle and wraps H_TOTAL-1 → 0.
  - On each wrap, v_cnt increments; v_cnt wraps V_TOTAL-1 → 0.
- **RUN → IDLE**
  - Taken only at the last cycle of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) with video_en=0.
  - Deasserting video_en mid-frame has no effect until that cycle.
  - If video_en is reasserted before the frame end, the controller continues seamlessly with no gap.
- **Decodes** (combinational from registered state/counters, all gated by state==RUN; outside RUN they take idle values):
  - video_hs = SYNC_POL when h_cnt < H_SYNC, else ~SYNC_POL.
  - video_vs = SYNC_POL when v_cnt < V_SYNC, else ~SYNC_POL.
  - video_de = (HA ≤ h_cnt < HA+H_DISP) && (VA ≤ v_cnt < VA+V_DISP).
  - data_req = (HA-1 ≤ h_cnt < HA+H_DISP-1) && (VA ≤ v_cnt < VA+V_DISP).
  - pixel_xpos = h_cnt-(HA-1) when data_req, else 0.
  - pixel_ypos = v_cnt-VA when data_req, else 0.
  - busy = (state==RUN).
- **Alignment**: pixel data registered one cycle after data_req coincides exactly with video_de. The last request of each line is xpos=H_DISP-1.
- **Width rules**
  - All comparisons are unsigned at 12 bits; subtraction results are truncated to 11 bits.
  - Parameters must satisfy H_TOTAL ≤ 4095, V_TOTAL ≤ 2047, HA ≥ 1.

Test Plan:
1. **Reset and idle.** Assert rst for 5 cycles, then release with video_en=0 for 2000 cycles → video_hs=video_vs=0, de=0, busy=0, xpos=ypos=0 throughout.
2. **Frame start.** Raise video_en → busy=1 and frame_start=1 on the next cycle. video_hs is high for 40 cycles in each 1650-cycle line. video_vs is high for 5 lines (8250 cycles) in each 750-line frame.
3. **Request/enable alignment.** Line v_cnt=25:
   - data_req rises at h_cnt=259 with xpos=0, ypos=0.
   - video_de rises at h_cnt=260.
   - The last request is at h_cnt=1538 with xpos=1279.
   - video_de falls after h_cnt=1539.
   - Exactly 1280 de cycles per line and 720 de lines per frame; ypos=719 on line 744.
4. **Stop mid-frame.** Drop video_en at v_cnt=300 → timing continues to h_cnt=1649/v_cnt=749. Idle values and busy=0 follow on the next cycle, with no truncated frame.
5. **Re-enable before the boundary.** Drop video_en at v_cnt=100, reassert at v_cnt=700 → no gap; frame_start pulses every 1,237,500 cycles.
6. **Asynchronous reset mid-frame.** Assert rst at h_cnt=800/v_cnt=400, without waiting for a clock edge → outputs go to idle values immediately. After release with video_en=1, the next frame starts from h_cnt=0/v_cnt=0.
